block_tile_scheduler: RTL and testbench
=======================================

Name: block_tile_scheduler

Overview:
- Sequences block matrix multiply C = A x B over the packed-byte BRAM holding A and B; 4 INT8 values per 32-bit word.
- Walks output tiles (i,j) in row-major order. For each tile it walks k, streaming A block (i,k) then B block (k,j) from the read port into one of NUM_CORES matrix cores, chosen by k mod NUM_CORES.
- After each tile it waits for the accumulator/writer to acknowledge before starting the next tile.
- Replaces the ad hoc address FSM inside the data mover; sits between the host run/done control and the core array plus result writer.

Parameters:
- MATRIX_SIZE, 128, matrix edge in elements.
- BLOCK_SIZE, 16, block edge in elements.
- NUM_CORES, 8, number of matrix cores; power of 2, <= MATRIX_SIZE/BLOCK_SIZE.
- AWIDTH, 13, BRAM word address width.
- Derived, localparam:
  - NB = MATRIX_SIZE/BLOCK_SIZE
  - BW = BLOCK_SIZE*BLOCK_SIZE/4 (words per block)
  - B_BASE = MATRIX_SIZE*MATRIX_SIZE/4 (word base of B)

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_run  in  1  start pulse; sampled only in IDLE.
- i_core_ready  in  NUM_CORES  per-core ready to accept a new k-slice.
- i_tile_ack  in  1  writer finished draining current output tile.
- o_addr  out  AWIDTH  BRAM read word address (registered).
- o_ce  out  1  BRAM read enable (registered).
- o_core_valid  out  NUM_CORES  one-hot; data valid on BRAM q for that core, 1 cycle after o_ce.
- o_phase  out  1  0 = word belongs to A block, 1 = B block; aligned with o_core_valid.
- o_slice_last  out  1  pulse with the final B word of a k-slice; aligned with o_core_valid.
- o_tile_i  out  log2(NB) max 1  current tile row.
- o_tile_j  out  log2(NB) max 1  current tile column.
- o_tile_start  out  1  1-cycle pulse when a tile's first slice begins.
- o_idle  out  1  high in IDLE.
- o_busy  out  1  high in any state except IDLE and DONE.
- o_done  out  1  1-cycle pulse in DONE.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; i, j, k, word_cnt = 0; all outputs 0 except o_idle = 1.
  - Asserting reset mid-operation aborts at the next edge. No partial-slice completion.
- States and transitions:
  - IDLE: if i_run, clear i, j, k and go to WAIT_CORE. o_tile_start pulses on that edge.
  - WAIT_CORE: if i_core_ready[k mod NUM_CORES], go to FETCH_A with word_cnt = 0. Otherwise hold; no reads issued.
  - FETCH_A: o_ce = 1, o_addr = (i*NB + k)*BW + word_cnt. After BW words, go to FETCH_B with word_cnt = 0.
  - FETCH_B: o_ce = 1, o_addr = B_BASE + (k*NB + j)*BW + word_cnt. After BW words:
    - if k < NB-1: k++, go to WAIT_CORE;
    - else: k = 0, go to WAIT_ACK.
  - WAIT_ACK: hold until i_tile_ack. Then advance j; if j wraps, set j = 0 and advance i.
    - If i and j both wrapped (last tile done), go to DONE.
    - Otherwise go to WAIT_CORE and pulse o_tile_start.
  - DONE: o_done = 1 for one cycle, then IDLE.
- Timing:
  - Minimum per slice: 1 WAIT_CORE cycle + 2*BW fetch cycles, back-to-back with no bubbles between A and B.
  - o_core_valid, o_phase and o_slice_last are o_ce-stage values registered once, matching 1-cycle BRAM read latency.
  - o_tile_i/o_tile_j update on the edge leaving WAIT_ACK and are stable for the whole tile.
- Input rules:
  - i_run outside IDLE is ignored.
  - i_tile_ack outside WAIT_ACK is ignored; it is not latched.
  - i_core_ready is checked only in WAIT_CORE. Deassertion during a fetch does not stall the fetch.
- Arithmetic:
  - Address computed in AWIDTH bits; the parameter set must satisfy 2*B_BASE <= 2^AWIDTH.
  - word_cnt is log2(BW) bits and wraps naturally.
  - k, i and j compare against NB-1; they never rely on power-of-2 masking, except core select = k mod NUM_CORES.
- Edge case NB = 1: single tile, single slice, then WAIT_ACK, then DONE.

Test Plan:
- Setup for the first five scenarios: MATRIX_SIZE=32, BLOCK_SIZE=16, NUM_CORES=2, giving NB=2, BW=64, B_BASE=256.
- Reset, then i_run with all cores ready:
  - first slice: o_addr 0..63 then 256..319;
  - o_core_valid = 2'b01 from 1 cycle after the first o_ce for 128 cycles;
  - o_phase switches 0->1 at word 64; o_slice_last on the 128th valid.
- Continue the same run:
  - second slice goes to core 1 (2'b10) with addresses 64..127 then 384..447;
  - then WAIT_ACK holds with o_ce = 0 until i_tile_ack;
  - tile (0,1) then reads A at 0..63 and B at 320..383.
- Hold i_core_ready[1] = 0 for 10 cycles at slice k=1: scheduler stays in WAIT_CORE exactly 10 extra cycles with no o_ce, then resumes at address 64.
- Full run, ack 3 cycles after each WAIT_ACK entry:
  - 4 o_tile_start pulses with (i,j) = (0,0), (0,1), (1,0), (1,1);
  - then one o_done pulse, then o_idle = 1;
  - i_run pulses during busy are ignored.
- Assert reset during FETCH_B of tile (1,0): next edge shows o_ce = 0, o_core_valid = 0, o_idle = 1; a new i_run restarts at address 0.
- Default parameters (NB=8, NUM_CORES=8), i_tile_ack tied high:
  - each tile takes 8*129 cycles + 1 ack cycle;
  - core select steps 0..7 per tile;
  - last B address = 4096 + 63*64 + 63 = 8191.

Source files
------------

// File: rtl/block_tile_scheduler_if.sv
// Handshake bundle between the host/core array/writer and the block tile scheduler.
// The master side drives run/ready/ack; the scheduler is the slave side.
interface block_tile_scheduler_if #(
    parameter int NUM_CORES = 8,
    parameter int AWIDTH    = 13,
    parameter int TW        = 3
);
    logic                 i_run;
    logic [NUM_CORES-1:0] i_core_ready;
    logic                 i_tile_ack;
    logic [AWIDTH-1:0]    o_addr;
    logic                 o_ce;
    logic [NUM_CORES-1:0] o_core_valid;
    logic                 o_phase;
    logic                 o_slice_last;
    logic [TW-1:0]        o_tile_i;
    logic [TW-1:0]        o_tile_j;
    logic                 o_tile_start;
    logic                 o_idle;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_run, i_core_ready, i_tile_ack,
        input  o_addr, o_ce, o_core_valid, o_phase, o_slice_last,
               o_tile_i, o_tile_j, o_tile_start, o_idle, o_busy, o_done
    );

    modport slave (
        input  i_run, i_core_ready, i_tile_ack,
        output o_addr, o_ce, o_core_valid, o_phase, o_slice_last,
               o_tile_i, o_tile_j, o_tile_start, o_idle, o_busy, o_done
    );
endinterface

// File: rtl/block_tile_scheduler.sv
// Walks output tiles (i,j) row-major and streams A(i,k) then B(k,j) block words
// from the packed-byte BRAM into matrix core k mod NUM_CORES.
module block_tile_scheduler #(
    parameter int MATRIX_SIZE = 128,
    parameter int BLOCK_SIZE  = 16,
    parameter int NUM_CORES   = 8,
    parameter int AWIDTH      = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    block_tile_scheduler_if.slave bus
);
    localparam int NB     = MATRIX_SIZE / BLOCK_SIZE;
    localparam int BW     = BLOCK_SIZE * BLOCK_SIZE / 4;
    localparam int B_BASE = MATRIX_SIZE * MATRIX_SIZE / 4;
    localparam int TW     = (NB > 1) ? $clog2(NB) : 1;
    localparam int WCW    = (BW > 1) ? $clog2(BW) : 1;
    localparam int CW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CORE, S_FETCH_A, S_FETCH_B, S_WAIT_ACK, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic                 ce_q, ce_d;
    logic [AWIDTH-1:0]    addr_q, addr_d;
    logic                 ph_ce_q, ph_ce_d;
    logic                 last_ce_q, last_ce_d;
    logic [CW-1:0]        csel_ce_q, csel_ce_d;
    logic [NUM_CORES-1:0] cv_q, cv_d;
    logic                 phase_q, phase_d;
    logic                 slast_q, slast_d;
    logic                 tstart_q, tstart_d;

    logic [CW-1:0]     csel;
    logic              wlast, k_last, i_last, j_last;
    logic [AWIDTH-1:0] a_addr, b_addr;

    assign csel   = CW'(int'(k_q) % NUM_CORES);
    assign wlast  = (wcnt_q == WCW'(BW - 1));
    assign k_last = (k_q == TW'(NB - 1));
    assign i_last = (i_q == TW'(NB - 1));
    assign j_last = (j_q == TW'(NB - 1));

    assign a_addr = (AWIDTH'(i_q) * AWIDTH'(NB) + AWIDTH'(k_q)) * AWIDTH'(BW)
                  + AWIDTH'(wcnt_q);
    assign b_addr = AWIDTH'(B_BASE)
                  + (AWIDTH'(k_q) * AWIDTH'(NB) + AWIDTH'(j_q)) * AWIDTH'(BW)
                  + AWIDTH'(wcnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            wcnt_q    <= '0;
            ce_q      <= 1'b0;
            addr_q    <= '0;
            ph_ce_q   <= 1'b0;
            last_ce_q <= 1'b0;
            csel_ce_q <= '0;
            cv_q      <= '0;
            phase_q   <= 1'b0;
            slast_q   <= 1'b0;
            tstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            wcnt_q    <= wcnt_d;
            ce_q      <= ce_d;
            addr_q    <= addr_d;
            ph_ce_q   <= ph_ce_d;
            last_ce_q <= last_ce_d;
            csel_ce_q <= csel_ce_d;
            cv_q      <= cv_d;
            phase_q   <= phase_d;
            slast_q   <= slast_d;
            tstart_q  <= tstart_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        wcnt_d    = wcnt_q;
        ce_d      = 1'b0;
        addr_d    = addr_q;
        ph_ce_d   = 1'b0;
        last_ce_d = 1'b0;
        csel_ce_d = csel_ce_q;
        tstart_d  = 1'b0;
        // Second stage: the BRAM word for the o_ce issued last cycle is on q now.
        cv_d      = ce_q ? (NUM_CORES'(1) << csel_ce_q) : '0;
        phase_d   = ce_q & ph_ce_q;
        slast_d   = ce_q & last_ce_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_run) begin
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    tstart_d = 1'b1;
                    state_d  = S_WAIT_CORE;
                end
            end
            S_WAIT_CORE: begin
                if (bus.i_core_ready[csel]) begin
                    wcnt_d  = '0;
                    state_d = S_FETCH_A;
                end
            end
            S_FETCH_A: begin
                ce_d      = 1'b1;
                addr_d    = a_addr;
                csel_ce_d = csel;
                wcnt_d    = wcnt_q + WCW'(1);
                if (wlast) begin
                    wcnt_d  = '0;
                    state_d = S_FETCH_B;
                end
            end
            S_FETCH_B: begin
                ce_d      = 1'b1;
                addr_d    = b_addr;
                ph_ce_d   = 1'b1;
                last_ce_d = wlast;
                csel_ce_d = csel;
                wcnt_d    = wcnt_q + WCW'(1);
                if (wlast) begin
                    wcnt_d = '0;
                    if (k_last) begin
                        k_d     = '0;
                        state_d = S_WAIT_ACK;
                    end else begin
                        k_d     = k_q + TW'(1);
                        state_d = S_WAIT_CORE;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (bus.i_tile_ack) begin
                    if (j_last) begin
                        j_d = '0;
                        if (i_last) begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            i_d      = i_q + TW'(1);
                            tstart_d = 1'b1;
                            state_d  = S_WAIT_CORE;
                        end
                    end else begin
                        j_d      = j_q + TW'(1);
                        tstart_d = 1'b1;
                        state_d  = S_WAIT_CORE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_addr       = addr_q;
    assign bus.o_ce         = ce_q;
    assign bus.o_core_valid = cv_q;
    assign bus.o_phase      = phase_q;
    assign bus.o_slice_last = slast_q;
    assign bus.o_tile_i     = i_q;
    assign bus.o_tile_j     = j_q;
    assign bus.o_tile_start = tstart_q;
    assign bus.o_idle       = (state_q == S_IDLE);
    assign bus.o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.o_done       = (state_q == S_DONE);
endmodule

// File: tb/tb_block_tile_scheduler.sv
// Bench: a 32x32/16 two-core instance checked through a read scoreboard, plus a
// default-parameter instance checked for tile timing, core rotation and B addressing.
module tb_block_tile_scheduler;
    localparam int S_NB = 2;
    localparam int S_BW = 64;
    localparam int S_BB = 256;

    typedef struct {
        logic [9:0] addr;
        int         core;
        bit         phase;
        bit         last;
    } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic       s_run = 1'b0, s_ack = 1'b0;
    logic [1:0] s_ready = 2'b00;
    logic       d_run = 1'b0;

    int  n_tests = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    rd_t exp_q[$];
    rd_t prec;
    bit  pv = 1'b0;

    always #5 clk = ~clk;

    block_tile_scheduler_if #(.NUM_CORES(2), .AWIDTH(10), .TW(1)) s_if ();
    block_tile_scheduler_if #(.NUM_CORES(8), .AWIDTH(13), .TW(3)) d_if ();

    assign s_if.i_run        = s_run;
    assign s_if.i_core_ready = s_ready;
    assign s_if.i_tile_ack   = s_ack;
    assign d_if.i_run        = d_run;
    assign d_if.i_core_ready = 8'hFF;
    assign d_if.i_tile_ack   = 1'b1;

    block_tile_scheduler #(.MATRIX_SIZE(32), .BLOCK_SIZE(16), .NUM_CORES(2), .AWIDTH(10))
        u_small (.clk(clk), .reset(reset), .bus(s_if));
    block_tile_scheduler u_dflt (.clk(clk), .reset(reset), .bus(d_if));

    // Scoreboard: every o_ce pops one expected read; its core/phase/last must show up on the next cycle.
    always @(negedge clk) begin
        if (!mon_en) begin
            pv = 1'b0;
        end else begin
            logic [1:0] exp_cv;
            bit         exp_last;
            rd_t        r;
            exp_cv   = pv ? 2'(1 << prec.core) : 2'b00;
            exp_last = pv ? prec.last : 1'b0;
            n_tests++;
            if (s_if.o_core_valid !== exp_cv || s_if.o_slice_last !== exp_last ||
                (pv && s_if.o_phase !== prec.phase)) begin
                n_fail++;
                $display("FAIL valid_stage: got cv=%b phase=%b last=%b, want cv=%b phase=%b last=%b",
                         s_if.o_core_valid, s_if.o_phase, s_if.o_slice_last,
                         exp_cv, prec.phase, exp_last);
            end
            if (s_if.o_ce === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_read: got addr=%0d, want no read", s_if.o_addr);
                    pv = 1'b0;
                end else begin
                    r = exp_q.pop_front();
                    if (s_if.o_addr !== r.addr) begin
                        n_fail++;
                        $display("FAIL read_addr: got %0d, want %0d", s_if.o_addr, r.addr);
                    end
                    pv   = 1'b1;
                    prec = r;
                end
            end else begin
                pv = 1'b0;
            end
        end
    end

    task automatic push_tile(input int ti, input int tj);
        rd_t r;
        for (int k = 0; k < S_NB; k++) begin
            for (int w = 0; w < S_BW; w++) begin
                r.addr = 10'((ti * S_NB + k) * S_BW + w);
                r.core = k % 2; r.phase = 1'b0; r.last = 1'b0;
                exp_q.push_back(r);
            end
            for (int w = 0; w < S_BW; w++) begin
                r.addr = 10'(S_BB + (k * S_NB + tj) * S_BW + w);
                r.core = k % 2; r.phase = 1'b1; r.last = (w == S_BW - 1);
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        exp_q.delete();
        s_run   = 1'b0; s_ack = 1'b0; s_ready = 2'b00; d_run = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic wait_q_empty(input int max, output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (s_if.o_idle !== 1'b1 || s_if.o_busy !== 1'b0 || s_if.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got idle=%b busy=%b done=%b, want 1 0 0",
                     s_if.o_idle, s_if.o_busy, s_if.o_done);
        end
        n_tests++;
        if (s_if.o_ce !== 1'b0 || s_if.o_addr !== 10'd0 || s_if.o_core_valid !== 2'b00 ||
            s_if.o_tile_start !== 1'b0 || s_if.o_slice_last !== 1'b0 || s_if.o_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ce=%b addr=%0d cv=%b ts=%b last=%b ph=%b, want all 0",
                     s_if.o_ce, s_if.o_addr, s_if.o_core_valid, s_if.o_tile_start,
                     s_if.o_slice_last, s_if.o_phase);
        end
        n_tests++;
        if (s_if.o_tile_i !== 1'b0 || s_if.o_tile_j !== 1'b0 || d_if.o_idle !== 1'b1 ||
            d_if.o_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tile: got i=%b j=%b dflt_idle=%b dflt_ce=%b, want 0 0 1 0",
                     s_if.o_tile_i, s_if.o_tile_j, d_if.o_idle, d_if.o_ce);
        end
    endtask

    task automatic test_first_tile();
        int n;
        bit ok;
        do_reset();
        s_ready = 2'b11;
        push_tile(0, 0);
        @(negedge clk) s_run = 1'b1;
        @(negedge clk) s_run = 1'b0;
        n_tests++;
        if (s_if.o_tile_start !== 1'b1 || s_if.o_busy !== 1'b1 || s_if.o_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL run_start: got ts=%b busy=%b idle=%b, want 1 1 0",
                     s_if.o_tile_start, s_if.o_busy, s_if.o_idle);
        end
        n = 0;
        while (s_if.o_ce !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n_tests++;
        if (n != 2) begin
            n_fail++; $display("FAIL first_read_latency: got %0d cycles, want 2", n);
        end
        n = 0;
        while (s_if.o_ce === 1'b1 && n < 300) begin
            s_ack = (n == 10);
            @(negedge clk);
            n++;
        end
        s_ack = 1'b0;
        n_tests++;
        if (n != 2 * S_BW) begin
            n_fail++; $display("FAIL slice0_burst: got %0d reads, want %0d", n, 2 * S_BW);
        end
        n = 0;
        while (s_if.o_ce !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_tests++;
        if (n != 1) begin
            n_fail++; $display("FAIL slice_gap: got %0d idle cycles, want 1", n);
        end
        n = 0;
        while (s_if.o_ce === 1'b1 && n < 300) begin @(negedge clk); n++; end
        n_tests++;
        if (n != 2 * S_BW) begin
            n_fail++; $display("FAIL slice1_burst: got %0d reads, want %0d", n, 2 * S_BW);
        end
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_if.o_ce === 1'b1) n++;
        end
        n_tests++;
        if (n != 0 || s_if.o_busy !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wait_ack_hold: got reads=%0d busy=%b pending=%0d, want 0 1 0",
                     n, s_if.o_busy, exp_q.size());
        end
        push_tile(0, 1);
        s_ack = 1'b1;
        @(negedge clk) s_ack = 1'b0;
        n_tests++;
        if (s_if.o_tile_start !== 1'b1 || s_if.o_tile_i !== 1'b0 || s_if.o_tile_j !== 1'b1) begin
            n_fail++;
            $display("FAIL tile01_start: got ts=%b i=%b j=%b, want 1 0 1",
                     s_if.o_tile_start, s_if.o_tile_i, s_if.o_tile_j);
        end
        wait_q_empty(600, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL tile01_reads: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_core_stall();
        int n;
        bit ok;
        do_reset();
        s_ready = 2'b01;
        push_tile(0, 0);
        @(negedge clk) s_run = 1'b1;
        @(negedge clk) s_run = 1'b0;
        n = 0;
        while (s_if.o_ce !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (s_if.o_ce === 1'b1 && n < 300) begin @(negedge clk); n++; end
        n = 0;
        while (s_if.o_ce !== 1'b1 && n < 50) begin
            n++;
            if (n == 10) s_ready = 2'b11;
            @(negedge clk);
        end
        n_tests++;
        if (n != 11) begin
            n_fail++; $display("FAIL stall_gap: got %0d idle cycles, want 11", n);
        end
        wait_q_empty(300, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL stall_reads: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_full_run();
        int starts = 0, dones = 0, slices = 0, ackcnt = 0;
        int ei[4] = '{0, 0, 1, 1};
        int ej[4] = '{0, 1, 0, 1};
        do_reset();
        s_ready = 2'b11;
        for (int t = 0; t < 4; t++) push_tile(ei[t], ej[t]);
        @(negedge clk) s_run = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (s_if.o_tile_start === 1'b1) begin
                n_tests++;
                if (starts >= 4) begin
                    n_fail++; $display("FAIL extra_tile_start: got start #%0d, want 4 total", starts + 1);
                end else if (int'(s_if.o_tile_i) != ei[starts] || int'(s_if.o_tile_j) != ej[starts]) begin
                    n_fail++;
                    $display("FAIL tile_order: got (%0d,%0d), want (%0d,%0d)",
                             s_if.o_tile_i, s_if.o_tile_j, ei[starts], ej[starts]);
                end
                starts++;
            end
            if (s_if.o_slice_last === 1'b1) begin
                slices++;
                if (slices % S_NB == 0) ackcnt = 3;
            end
            if (ackcnt > 0) begin
                ackcnt--;
                s_ack = (ackcnt == 0);
            end else begin
                s_ack = 1'b0;
            end
            s_run = (s_if.o_busy === 1'b1) && (starts < 4) && (c % 37 == 0);
            if (s_if.o_done === 1'b1) begin
                dones++;
                break;
            end
        end
        s_run = 1'b0;
        s_ack = 1'b0;
        n_tests++;
        if (starts != 4 || dones != 1) begin
            n_fail++; $display("FAIL full_run: got starts=%0d done=%0d, want 4 1", starts, dones);
        end
        @(negedge clk);
        n_tests++;
        if (s_if.o_done !== 1'b0 || s_if.o_idle !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL after_done: got done=%b idle=%b pending=%0d, want 0 1 0",
                     s_if.o_done, s_if.o_idle, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int hits = 0;
        bit ok;
        do_reset();
        mon_en  = 1'b0;
        s_ready = 2'b11;
        s_ack   = 1'b1;
        @(negedge clk) s_run = 1'b1;
        @(negedge clk) s_run = 1'b0;
        for (int c = 0; c < 1500 && hits < 5; c++) begin
            @(negedge clk);
            if (s_if.o_tile_i === 1'b1 && s_if.o_tile_j === 1'b0 && s_if.o_ce === 1'b1 &&
                s_if.o_addr >= 10'(S_BB)) hits++;
        end
        n_tests++;
        if (hits != 5) begin
            n_fail++; $display("FAIL reach_tile10_fetch_b: got %0d hits, want 5", hits);
        end
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (s_if.o_ce !== 1'b0 || s_if.o_core_valid !== 2'b00 || s_if.o_idle !== 1'b1 ||
            s_if.o_busy !== 1'b0 || s_if.o_tile_i !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got ce=%b cv=%b idle=%b busy=%b i=%b, want 0 00 1 0 0",
                     s_if.o_ce, s_if.o_core_valid, s_if.o_idle, s_if.o_busy, s_if.o_tile_i);
        end
        reset = 1'b0;
        s_ack = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        push_tile(0, 0);
        @(negedge clk) s_run = 1'b1;
        @(negedge clk) s_run = 1'b0;
        wait_q_empty(400, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL restart_reads: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_default_params();
        int cyc = 0, last_start = 0, starts = 0, slice = 0;
        int last_addr = -1;
        logic [7:0] prev_cv = 8'h00;
        do_reset();
        mon_en = 1'b0;
        @(negedge clk) d_run = 1'b1;
        for (int c = 0; c < 9000 && starts < 9; c++) begin
            @(negedge clk);
            d_run = 1'b0;
            cyc++;
            if (d_if.o_tile_start === 1'b1) begin
                if (starts > 0) begin
                    n_tests++;
                    if (cyc - last_start != 8 * 129 + 1 || slice != 8) begin
                        n_fail++;
                        $display("FAIL dflt_tile_period: got %0d cycles %0d slices, want 1033 8",
                                 cyc - last_start, slice);
                    end
                    n_tests++;
                    if (last_addr != 4096 + (56 + starts - 1) * 64 + 63) begin
                        n_fail++;
                        $display("FAIL dflt_last_b_addr: got %0d, want %0d",
                                 last_addr, 4096 + (56 + starts - 1) * 64 + 63);
                    end
                end
                n_tests++;
                if (int'(d_if.o_tile_i) != starts / 8 || int'(d_if.o_tile_j) != starts % 8) begin
                    n_fail++;
                    $display("FAIL dflt_tile_order: got (%0d,%0d), want (%0d,%0d)",
                             d_if.o_tile_i, d_if.o_tile_j, starts / 8, starts % 8);
                end
                last_start = cyc;
                starts++;
                slice = 0;
            end
            if (d_if.o_core_valid !== 8'h00 && prev_cv === 8'h00) begin
                n_tests++;
                if (d_if.o_core_valid !== 8'(1 << (slice % 8))) begin
                    n_fail++;
                    $display("FAIL dflt_core_sel: got %b, want %b",
                             d_if.o_core_valid, 8'(1 << (slice % 8)));
                end
                slice++;
            end
            prev_cv = d_if.o_core_valid;
            if (d_if.o_ce === 1'b1) last_addr = int'(d_if.o_addr);
        end
        n_tests++;
        if (starts != 9) begin
            n_fail++; $display("FAIL dflt_progress: got %0d tile starts, want 9", starts);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_tile();
        test_core_stall();
        test_full_run();
        test_reset_mid();
        test_default_params();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
